// File: rtl/pool_frame_buffer_if.sv
// Stream interface between the max-pooling stage, the ping-pong frame buffer and the next layer.
interface pool_frame_buffer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] pixel_in;
    logic          i_data_valid;
    logic [DW-1:0] o_pixel;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
    logic          o_frame_done;
    logic          o_overflow;

    modport master (
        output pixel_in, i_data_valid, i_ready,
        input  o_pixel, o_valid, o_last, o_frame_done, o_overflow
    );

    modport slave (
        input  pixel_in, i_data_valid, i_ready,
        output o_pixel, o_valid, o_last, o_frame_done, o_overflow
    );
endinterface

// File: rtl/pool_frame_buffer.sv
// Ping-pong frame buffer: captures pooled frames into two banks and streams
// completed frames in arrival order over a valid/ready output.
module pool_frame_buffer #(
    parameter int PW = 14,
    parameter int PH = 14,
    parameter int DW = 16
)(
    input  logic              clk,
    input  logic              reset,
    pool_frame_buffer_if.slave bus
);
    localparam int N  = PW * PH;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    logic [DW-1:0] mem [0:1][0:N-1];

    rd_state_t     state;
    logic          wr_bank, rd_bank;
    logic [AW-1:0] wr_addr, rd_addr, rd_next;
    logic [1:0]    full;
    logic [DW-1:0] pixel;
    logic          valid, last, frame_done, overflow;
    logic          accept, fill, rd_done;

    // Acceptance and release decisions all use pre-edge state, so a bank
    // freed on this edge only becomes writable on the next one.
    always_comb begin
        accept  = reset && bus.i_data_valid && !full[wr_bank];
        fill    = accept && (wr_addr == LAST);
        rd_done = valid && bus.i_ready && last;
        rd_next = rd_addr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_bank][wr_addr] <= bus.pixel_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= R_IDLE;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            full       <= 2'b00;
            pixel      <= '0;
            valid      <= 1'b0;
            last       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= fill;
            if (bus.i_data_valid && full[wr_bank])
                overflow <= 1'b1;

            if (accept) begin
                if (fill) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end

            // A filling bank and a releasing bank are always different banks.
            if (fill)
                full[wr_bank] <= 1'b1;
            if (rd_done)
                full[rd_bank] <= 1'b0;

            case (state)
                R_IDLE: begin
                    valid <= 1'b0;
                    last  <= 1'b0;
                    pixel <= '0;
                    if (full[rd_bank]) begin
                        state   <= R_STREAM;
                        rd_addr <= '0;
                    end
                end
                R_STREAM: begin
                    // First cycle in R_STREAM loads the output register from the bank.
                    if (!valid) begin
                        valid <= 1'b1;
                        pixel <= mem[rd_bank][rd_addr];
                        last  <= (rd_addr == LAST);
                    end else if (bus.i_ready) begin
                        if (last) begin
                            state   <= R_IDLE;
                            valid   <= 1'b0;
                            last    <= 1'b0;
                            pixel   <= '0;
                            rd_addr <= '0;
                            rd_bank <= ~rd_bank;
                        end else begin
                            rd_addr <= rd_next;
                            pixel   <= mem[rd_bank][rd_next];
                            last    <= (rd_next == LAST);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign bus.o_pixel      = pixel;
    assign bus.o_valid      = valid;
    assign bus.o_last       = last;
    assign bus.o_frame_done = frame_done;
    assign bus.o_overflow   = overflow;
endmodule

// File: tb/tb_pool_frame_buffer.sv
// Bench for pool_frame_buffer: table-driven start-up sequence, directed corner
// sequences and random traffic, all scored against a frame-queue model.
module tb_pool_frame_buffer;
    localparam int PW   = 14;
    localparam int PH   = 14;
    localparam int DW   = 16;
    localparam int N    = PW * PH;
    localparam int MASK = (1 << DW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pool_frame_buffer_if #(.DW(DW)) bus_if();

    pool_frame_buffer #(.PW(PW), .PH(PH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: the buffer is a FIFO of whole frames holding at most two frames
    // (counting the one being streamed); a pixel is dropped while it holds two.
    int occ, n_pushed, n_xfer, out_idx;
    bit exp_ovf;
    int part[$];
    int expq[$];

    typedef struct {
        bit dv; int px; bit rdy;
        bit v;  int pix; bit last; bit fd;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        occ = 0; n_pushed = 0; n_xfer = 0; out_idx = 0; exp_ovf = 0;
        part.delete();
        expq.delete();
    endtask

    // One clock: drive inputs, score the handshake about to happen, advance, check.
    task automatic cycle(input bit dv, input int px, input bit rdy);
        bit fd_exp, stall, h_valid, h_last, occ_dec;
        int h_pix;
        bus_if.i_data_valid = dv;
        bus_if.pixel_in     = DW'(px);
        bus_if.i_ready      = rdy;
        fd_exp  = 0;
        occ_dec = 0;
        h_valid = bus_if.o_valid;
        h_pix   = int'(bus_if.o_pixel);
        h_last  = bus_if.o_last;
        stall   = h_valid && !rdy;
        if (h_valid && rdy) begin
            if (expq.size() == 0) chk("xfer_unexpected", h_pix, -1);
            else                  chk("xfer_pixel", h_pix, expq.pop_front());
            chk("xfer_last", int'(h_last), int'(out_idx == N - 1));
            n_xfer++;
            out_idx++;
            if (out_idx == N) begin
                out_idx = 0;
                occ_dec = 1;
            end
        end
        if (dv) begin
            if (occ < 2) begin
                part.push_back(px & MASK);
                if (part.size() == N) begin
                    foreach (part[i]) expq.push_back(part[i]);
                    part.delete();
                    n_pushed++;
                    occ++;
                    fd_exp = 1;
                end
            end else begin
                exp_ovf = 1;
            end
        end
        if (occ_dec) occ--;
        @(posedge clk);
        #1;
        chk("frame_done", int'(bus_if.o_frame_done), int'(fd_exp));
        chk("overflow", int'(bus_if.o_overflow), int'(exp_ovf));
        if (stall) begin
            chk("hold_valid", int'(bus_if.o_valid), 1);
            chk("hold_pixel", int'(bus_if.o_pixel), h_pix);
            chk("hold_last", int'(bus_if.o_last), int'(h_last));
        end
        if (!bus_if.o_valid) begin
            chk("idle_pixel", int'(bus_if.o_pixel), 0);
            chk("idle_last", int'(bus_if.o_last), 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) begin
            bus_if.i_data_valid = 1'($urandom_range(0, 1));
            bus_if.pixel_in     = DW'($urandom_range(0, MASK));
            bus_if.i_ready      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        model_clear();
        chk("rst_valid", int'(bus_if.o_valid), 0);
        chk("rst_pixel", int'(bus_if.o_pixel), 0);
        chk("rst_last", int'(bus_if.o_last), 0);
        chk("rst_frame_done", int'(bus_if.o_frame_done), 0);
        chk("rst_overflow", int'(bus_if.o_overflow), 0);
        reset = 1'b1;
        bus_if.i_data_valid = 1'b0;
        bus_if.pixel_in     = '0;
        bus_if.i_ready      = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int k = 0;
        while ((expq.size() != 0 || bus_if.o_valid) && k < 2000) begin
            cycle(1'b0, 0, toggle ? (k % 2 == 0) : 1'b1);
            k++;
        end
        chk("drain_left", expq.size(), 0);
        chk("xfer_count", n_xfer, n_pushed * N);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, v;
        tbl[0] = '{1, 196,  1, 0, 0, 0, 1};
        tbl[1] = '{0, 0,    1, 0, 0, 0, 0};
        tbl[2] = '{0, 0,    1, 1, 1, 0, 0};
        tbl[3] = '{0, 0,    0, 1, 1, 0, 0};
        tbl[4] = '{0, 0,    1, 1, 2, 0, 0};
        tbl[5] = '{0, 0,    1, 1, 3, 0, 0};
        tbl[6] = '{0, 0,    0, 1, 3, 0, 0};
        tbl[7] = '{1, 2001, 1, 1, 4, 0, 0};

        reset = 1'b0;
        bus_if.i_data_valid = 1'b0;
        bus_if.pixel_in     = '0;
        bus_if.i_ready      = 1'b0;
        do_reset(2);

        // Frame 1..196, exact start-up latency, then frame B written while A drains.
        for (int i = 1; i <= 195; i++) cycle(1'b1, i, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].dv, tbl[i].px, tbl[i].rdy);
            chk("tbl_valid", int'(bus_if.o_valid), int'(tbl[i].v));
            chk("tbl_pixel", int'(bus_if.o_pixel), tbl[i].pix);
            chk("tbl_last", int'(bus_if.o_last), int'(tbl[i].last));
            chk("tbl_frame_done", int'(bus_if.o_frame_done), int'(tbl[i].fd));
        end
        for (int i = 2002; i <= 2196; i++) cycle(1'b1, i, 1'b1);
        drain(1'b0);

        // Two frames with the consumer stalled, then an overflow and release-edge drops.
        do_reset(1);
        for (int i = 1; i <= 196; i++) cycle(1'b1, i, 1'b0);
        for (int i = 1001; i <= 1196; i++) cycle(1'b1, i, 1'b0);
        cycle(1'b1, 9999, 1'b0);
        chk("ovf_both_full", int'(bus_if.o_overflow), 1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 5000 + i, 1'b1);
        drain(1'b0);
        chk("ovf_sticky", int'(bus_if.o_overflow), 1);

        // Sparse writes (1 in 3) while i_ready toggles every cycle.
        do_reset(1);
        k = 0;
        v = 0;
        while (v < N) begin
            if (k % 3 == 0) v++;
            cycle(k % 3 == 0, 7000 + v, k % 2 == 0);
            k++;
        end
        drain(1'b1);

        // Reset in the middle of a write, and again in the middle of a read.
        do_reset(1);
        for (int i = 0; i < 100; i++) cycle(1'b1, 100 + i, 1'b1);
        do_reset(1);
        for (int i = 1; i <= 196; i++) cycle(1'b1, i, 1'b1);
        k = 0;
        while (out_idx != 50 && k < 500) begin
            cycle(1'b0, 0, 1'b1);
            k++;
        end
        chk("reach_read_50", out_idx, 50);
        do_reset(1);
        for (int i = 301; i <= 496; i++) cycle(1'b1, i, 1'b1);
        drain(1'b0);

        // Random traffic.
        do_reset(1);
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, MASK)), $urandom_range(0, 2) != 0);
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
